// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the ALU control slice.
//   * ALU operation codes driven on aluSel
//   * MIPS-style opcode / funct values recognised by the decoder
//   * controller state encoding and decoded instruction class
// ---------------------------------------------------------------------------
package alu_pkg;

  // ALU operation codes (only these values ever appear on aluSel)
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // Decoded instruction class, selects the path through EXEC/MEM/WB
  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_ALUI  = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_BNE   = 3'd5
  } instClass_t;

endpackage

// File: rtl/alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode -- purely combinational instruction decoder.
//   opcode, funct : latched instruction fields
//   aluSel        : ALU operation for this instruction
//   srcB          : 0 = register operand, 1 = sign-extended immediate
//   instClass     : path class used by the controller FSM
//   illegal       : opcode/funct combination is not supported
// ---------------------------------------------------------------------------
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] aluSel,
  output logic       srcB,
  output instClass_t instClass,
  output logic       illegal
);

  always_comb begin
    aluSel    = ALU_AND;
    srcB      = 1'b0;
    instClass = CLS_RTYPE;
    illegal   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        instClass = CLS_RTYPE;
        unique case (funct)
          FN_ADD:  aluSel = ALU_ADD;
          FN_SUB:  aluSel = ALU_SUB;
          FN_AND:  aluSel = ALU_AND;
          FN_OR:   aluSel = ALU_OR;
          FN_NOR:  aluSel = ALU_NOR;
          FN_SLT:  aluSel = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin instClass = CLS_ALUI;  aluSel = ALU_ADD; srcB = 1'b1; end
      OP_ANDI: begin instClass = CLS_ALUI;  aluSel = ALU_AND; srcB = 1'b1; end
      OP_ORI:  begin instClass = CLS_ALUI;  aluSel = ALU_OR;  srcB = 1'b1; end
      OP_SLTI: begin instClass = CLS_ALUI;  aluSel = ALU_SLT; srcB = 1'b1; end
      OP_LW:   begin instClass = CLS_LOAD;  aluSel = ALU_ADD; srcB = 1'b1; end
      OP_SW:   begin instClass = CLS_STORE; aluSel = ALU_ADD; srcB = 1'b1; end
      // Branches compare two registers, so the immediate is not the B operand
      OP_BEQ:  begin instClass = CLS_BEQ;   aluSel = ALU_SUB; end
      OP_BNE:  begin instClass = CLS_BNE;   aluSel = ALU_SUB; end
      default: illegal = 1'b1;
    endcase
    // Keep aluSel at a defined, legal value for unsupported encodings
    if (illegal) begin
      aluSel = ALU_AND;
      srcB   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// alu_ctrl_fsm -- multi-cycle control FSM for a small MIPS-style datapath.
//   clk, rst          : clock, synchronous active-high reset
//   instValid/Ready   : instruction handshake (see below)
//   opcode, funct     : instruction fields, latched on accept
//   aZero             : ALU zero flag (combinational from the ALU)
//   memReady          : memory access complete
//   aluSel, srcB      : ALU control, driven in EXEC and MEM
//   memRead/memWrite  : memory strobes, held in MEM until memReady
//   regWrite, regDst, memToReg : write-back control, driven in WB
//   branchTaken       : one-cycle pulse in EXEC for a taken beq/bne
//   illegal           : one-cycle pulse in DECODE for an unsupported op
//   stateDbg          : current FSM state
//
// Handshake: an instruction transfers on a rising clk edge where
// instValid=1 and instReady=1. instReady is high only in IDLE (and never
// while rst=1); instValid is ignored in every other state, so an upstream
// source may hold instValid high and it is simply taken at the next IDLE.
// ---------------------------------------------------------------------------
module alu_ctrl_fsm
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       instValid,
  output logic       instReady,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       aZero,
  input  logic       memReady,
  output logic [3:0] aluSel,
  output logic       srcB,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       branchTaken,
  output logic       illegal,
  output state_t     stateDbg
);

  state_t     state;
  state_t     nextState;
  logic [5:0] opReg;
  logic [5:0] fnReg;

  logic [3:0] decAluSel;
  logic       decSrcB;
  instClass_t decClass;
  logic       decIllegal;

  logic accept;

  alu_decode uDecode (
    .opcode    (opReg),
    .funct     (fnReg),
    .aluSel    (decAluSel),
    .srcB      (decSrcB),
    .instClass (decClass),
    .illegal   (decIllegal)
  );

  assign instReady = (state == ST_IDLE) && !rst;
  assign accept    = instValid && instReady;
  assign stateDbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      opReg <= 6'd0;
      fnReg <= 6'd0;
    end else begin
      state <= nextState;
      if (accept) begin
        opReg <= opcode;
        fnReg <= funct;
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE:   if (instValid) nextState = ST_DECODE;
      ST_DECODE: nextState = decIllegal ? ST_IDLE : ST_EXEC;
      ST_EXEC: begin
        unique case (decClass)
          CLS_LOAD, CLS_STORE: nextState = ST_MEM;
          CLS_BEQ, CLS_BNE:    nextState = ST_IDLE;
          default:             nextState = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (memReady) nextState = (decClass == CLS_LOAD) ? ST_WB : ST_IDLE;
      end
      ST_WB:   nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Outputs come from state plus the latched instruction. They are forced
  // low while rst is high so a reset landing in MEM/WB cannot leak a
  // memWrite or regWrite for the aborted instruction in that same cycle.
  always_comb begin
    aluSel      = ALU_AND;
    srcB        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    branchTaken = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_DECODE: illegal = decIllegal;
        ST_EXEC: begin
          aluSel      = decAluSel;
          srcB        = decSrcB;
          branchTaken = ((decClass == CLS_BEQ) &&  aZero) ||
                        ((decClass == CLS_BNE) && !aZero);
        end
        ST_MEM: begin
          aluSel   = decAluSel;
          srcB     = decSrcB;
          memRead  = (decClass == CLS_LOAD);
          memWrite = (decClass == CLS_STORE);
        end
        ST_WB: begin
          regWrite = 1'b1;
          regDst   = (decClass == CLS_RTYPE);
          memToReg = (decClass == CLS_LOAD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_fsm -- directed bench for alu_ctrl_fsm.
// The driver sets inputs just after each rising edge and pushes the
// hand-computed output vector expected for that cycle; the monitor pops one
// entry on every falling edge and compares it with the DUT outputs.
// Vector layout: {state[2:0], instReady, aluSel[3:0], srcB, memRead,
//                 memWrite, regWrite, regDst, memToReg, branchTaken, illegal}
// ---------------------------------------------------------------------------
module tb_alu_ctrl_fsm;

  localparam int W = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DEC  = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       instValid;
  logic       instReady;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       aZero;
  logic       memReady;
  logic [3:0] aluSel;
  logic       srcB, memRead, memWrite, regWrite, regDst, memToReg;
  logic       branchTaken, illegal;
  logic [2:0] stateDbg;

  always #5 clk = ~clk;

  alu_ctrl_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .instValid   (instValid),
    .instReady   (instReady),
    .opcode      (opcode),
    .funct       (funct),
    .aZero       (aZero),
    .memReady    (memReady),
    .aluSel      (aluSel),
    .srcB        (srcB),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .regWrite    (regWrite),
    .regDst      (regDst),
    .memToReg    (memToReg),
    .branchTaken (branchTaken),
    .illegal     (illegal),
    .stateDbg    (stateDbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  string        testName;
  int           nCompared   = 0;
  int           nMismatched = 0;

  function automatic logic [W-1:0] ev(
    input logic [2:0] st, input logic ir, input logic [3:0] alu,
    input logic sb, input logic mr, input logic mw, input logic rw,
    input logic rd, input logic m2r, input logic bt, input logic ill);
    return {st, ir, alu, sb, mr, mw, rw, rd, m2r, bt, ill};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    string        nm;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {stateDbg, instReady, aluSel, srcB, memRead, memWrite,
              regWrite, regDst, memToReg, branchTaken, illegal};
      nCompared++;
      if (got !== want) begin
        nMismatched++;
        $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, want, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Push the expectation for the current cycle, then advance one cycle.
  task automatic tick(input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(testName);
    @(posedge clk);
    #1;
  endtask

  task automatic idleAccept(input logic [5:0] op, input logic [5:0] fn);
    opcode    = op;
    funct     = fn;
    instValid = 1'b1;
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    instValid = 1'b0;
    // Scramble the bus after accept; the DUT must use its latched copy
    opcode    = ~op;
    funct     = ~fn;
  endtask

  task automatic runAlu(input logic [5:0] op, input logic [5:0] fn,
                        input logic [3:0] alu, input logic sb, input logic isR);
    idleAccept(op, fn);
    tick(ev(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    aZero = 1'($urandom_range(0, 1));
    tick(ev(S_EXEC, 0, alu, sb, 0, 0, 0, 0, 0, 0, 0));
    tick(ev(S_WB, 0, 0, 0, 0, 0, 1, isR, 0, 0, 0));
    aZero = 1'b0;
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic runBranch(input logic [5:0] op, input logic z, input logic bt);
    idleAccept(op, 6'($urandom_range(0, 63)));
    tick(ev(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    aZero = z;
    tick(ev(S_EXEC, 0, 4'd6, 0, 0, 0, 0, 0, 0, bt, 0));
    aZero = 1'b0;
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic runMem(input logic isLoad, input int waitCycles);
    idleAccept(isLoad ? 6'h23 : 6'h2B, 6'h00);
    tick(ev(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    memReady = 1'b1;  // memReady is ignored outside MEM
    tick(ev(S_EXEC, 0, 4'd2, 1, 0, 0, 0, 0, 0, 0, 0));
    memReady = 1'b0;
    for (int i = 0; i < waitCycles; i++)
      tick(ev(S_MEM, 0, 4'd2, 1, isLoad, !isLoad, 0, 0, 0, 0, 0));
    memReady = 1'b1;
    tick(ev(S_MEM, 0, 4'd2, 1, isLoad, !isLoad, 0, 0, 0, 0, 0));
    memReady = 1'b0;
    if (isLoad) tick(ev(S_WB, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic runIllegal(input logic [5:0] op, input logic [5:0] fn);
    idleAccept(op, fn);
    tick(ev(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; instValid = 1'b0; opcode = 6'h00; funct = 6'h00;
    aZero = 1'b0; memReady = 1'b0;
    testName = "reset";
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick(ev(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));     // instReady low in reset
    rst = 1'b0;
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));     // first IDLE after release

    testName = "r_add";  runAlu(6'h00, 6'h20, 4'd2,  0, 1);
    testName = "r_sub";  runAlu(6'h00, 6'h22, 4'd6,  0, 1);
    testName = "r_and";  runAlu(6'h00, 6'h24, 4'd0,  0, 1);
    testName = "r_or";   runAlu(6'h00, 6'h25, 4'd1,  0, 1);
    testName = "r_slt";  runAlu(6'h00, 6'h2A, 4'd7,  0, 1);
    testName = "addi";   runAlu(6'h08, 6'h15, 4'd2,  1, 0);
    testName = "andi";   runAlu(6'h0C, 6'h00, 4'd0,  1, 0);
    testName = "ori";    runAlu(6'h0D, 6'h3F, 4'd1,  1, 0);

    testName = "lw_wait2"; runMem(1, 2);
    testName = "lw_wait0"; runMem(1, 0);
    testName = "sw_wait1"; runMem(0, 1);

    testName = "beq_z1"; runBranch(6'h04, 1, 1);
    testName = "beq_z0"; runBranch(6'h04, 0, 0);
    testName = "bne_z1"; runBranch(6'h05, 1, 0);
    testName = "bne_z0"; runBranch(6'h05, 0, 1);

    testName = "ill_funct"; runIllegal(6'h00, 6'h03);
    testName = "ill_op";    runIllegal(6'h3F, 6'h20);

    // sw aborted by reset while waiting in MEM
    testName = "sw_rst";
    idleAccept(6'h2B, 6'h00);
    tick(ev(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(ev(S_EXEC, 0, 4'd2, 1, 0, 0, 0, 0, 0, 0, 0));
    tick(ev(S_MEM, 0, 4'd2, 1, 0, 1, 0, 0, 0, 0, 0));
    rst = 1'b1;
    tick(ev(S_MEM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));      // outputs quiet in reset
    rst = 1'b0;
    memReady = 1'b1;
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));     // no WB, no memWrite
    memReady = 1'b0;
    testName = "post_rst_add"; runAlu(6'h00, 6'h20, 4'd2, 0, 1);

    // lw aborted by reset in WB: regWrite must drop
    testName = "lw_rst_wb";
    idleAccept(6'h23, 6'h00);
    tick(ev(S_DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(ev(S_EXEC, 0, 4'd2, 1, 0, 0, 0, 0, 0, 0, 0));
    memReady = 1'b1;
    tick(ev(S_MEM, 0, 4'd2, 1, 1, 0, 0, 0, 0, 0, 0));
    memReady = 1'b0;
    rst = 1'b1;
    tick(ev(S_WB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // nor then slti with instValid held high throughout
    testName = "b2b_nor";
    opcode = 6'h00; funct = 6'h27; instValid = 1'b1;
    tick(ev(S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    opcode = 6'h0A; funct = 6'h11;
    tick(ev(S_DEC,  0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    tick(ev(S_EXEC, 0, 4'd12, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(ev(S_WB,   0, 0,     0, 0, 0, 1, 1, 0, 0, 0));
    testName = "b2b_slti";
    tick(ev(S_IDLE, 1, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    opcode = 6'h00; funct = 6'h20;
    tick(ev(S_DEC,  0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    tick(ev(S_EXEC, 0, 4'd7,  1, 0, 0, 0, 0, 0, 0, 0));
    instValid = 1'b0;
    tick(ev(S_WB,   0, 0,     0, 0, 0, 1, 0, 0, 0, 0));
    tick(ev(S_IDLE, 1, 0,     0, 0, 0, 0, 0, 0, 0, 0));

    // let the monitor drain the last entry
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      nMismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
